fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch unit and decode.
- Absorbs FETCH_WIDTH-wide fetch bundles into a circular buffer of single-instruction entries, compacting out invalid lanes.
- Presents up to FETCH_WIDTH oldest instructions per cycle to decode on decode's if_valid/if_pc/if_instr inputs.
- Honours decode_stall as dequeue backpressure and supports a single-cycle flush on redirect.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, at least 2*FETCH_WIDTH.
- FETCH_WIDTH, core_pkg::FETCH_WIDTH (2), lanes per enqueue and per dequeue.
- XLEN, core_pkg::XLEN (32), PC and instruction width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  redirect/mispredict; discards all queued and incoming instructions.
- fetch_valid  in  FETCH_WIDTH  per-lane valid from fetch; any lane pattern is allowed.
- fetch_pc  in  XLEN x FETCH_WIDTH  per-lane PC.
- fetch_instr  in  XLEN x FETCH_WIDTH  per-lane instruction word.
- fq_ready  out  1  queue accepts the fetch bundle this cycle.
- fq_valid  out  FETCH_WIDTH  per-lane valid to decode (if_valid).
- fq_pc  out  XLEN x FETCH_WIDTH  to decode if_pc.
- fq_instr  out  XLEN x FETCH_WIDTH  to decode if_instr.
- decode_stall  in  1  from decode; high means no lanes are consumed this cycle.
- fq_count  out  $clog2(DEPTH+1)  current occupancy (registered).

Behaviour:
- State:
  - entry arrays pc_q[DEPTH] and instr_q[DEPTH].
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH naturally.
  - count register.
- Reset: head=tail=count=0. Outputs are then fq_valid=0, fq_pc=0, fq_instr=0, fq_count=0, fq_ready=1. Entry contents are not reset.
- fq_ready = !flush && (count <= DEPTH-FETCH_WIDTH).
  - Uses current count only; same-cycle dequeue is not credited.
  - A bundle is accepted whole or not at all.
- Enqueue, when fetch_valid!=0 and fq_ready:
  - n_enq = popcount(fetch_valid).
  - Valid lanes are written in ascending lane order to tail, tail+1, ... (compaction).
  - tail += n_enq.
  - Invalid lanes consume no entry.
- Dequeue output (combinational from storage and count, independent of decode_stall):
  - Lane i is valid iff i < count and !flush.
  - fq_pc[i] = pc_q[head+i] and fq_instr[i] = instr_q[head+i], indices modulo DEPTH.
  - Invalid lanes drive 0.
  - Valid lanes are always contiguous from lane 0.
- Pop: when !decode_stall, n_deq = popcount(fq_valid) and head += n_deq. When decode_stall=1, n_deq=0 and outputs hold stable next cycle (unless new enqueue extends them).
- Count update: count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue is legal and exact.
- Latency: an instruction enqueued in cycle N is visible on fq_* in cycle N+1 at the earliest (no bypass).
- Flush (takes priority over everything):
  - In the flush cycle, fq_valid=0, fq_ready=0, and the incoming bundle is dropped.
  - Next cycle head=tail=count=0.
- Reset asserted mid-operation behaves identically to flush, and also forces fq_ready low in that cycle.
- Full: count > DEPTH-FETCH_WIDTH drops fq_ready even if 1 slot remains. Fetch holds its bundle.
- Empty: count=0 means all lanes invalid, no pop.
- Combinational loop avoidance: decode_stall depends on fq_valid, and fq_valid must not depend on decode_stall.

Decomposition:
- core_pkg supplies XLEN and FETCH_WIDTH.
- Add FQ_DEPTH=16 and the derived FQ_PTR_W/FQ_CNT_W to core_pkg.
- No typedef required; optionally fq_entry_t {pc, instr} packed struct in core_pkg.
- One natural sub-module: popcount_lanes (FETCH_WIDTH-bit popcount), used for n_enq and n_deq.
- The rest stays flat.

Test Plan:
- Reset then idle:
  - Assert reset 2 cycles -> fq_count=0, fq_valid=00, fq_ready=1.
  - A bundle presented during reset is not stored.
- Basic flow:
  - Enqueue pc=0x100/0x104 with fetch_valid=11, decode_stall=0 -> next cycle fq_valid=11, fq_pc={0x100,0x104}.
  - Following cycle count=0.
- Compaction:
  - Enqueue fetch_valid=10 (pc 0x204), then fetch_valid=01 (pc 0x208) while stalled.
  - -> fq_valid=11, lane0 pc 0x204, lane1 pc 0x208, count=2.
- Fill and backpressure:
  - Stall decode, enqueue 8 full bundles -> count=16, fq_ready=0.
  - Enqueue a 9th bundle -> dropped, count stays 16.
  - Release stall -> 2 pops/cycle and fq_ready=1 when count<=14.
- Wrap-around with simultaneous enq/deq:
  - Stream 40 sequential PCs with random stall -> order preserved across pointer wrap.
  - Count never exceeds 16, no duplicates or loss.
- Flush mid-stream:
  - With count=7, assert flush alongside an incoming bundle -> flush-cycle fq_valid=00.
  - Next cycle count=0, incoming bundle absent.
  - First post-flush bundle appears at lane 0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Core-wide widths shared by the front end and the fetch queue.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;
    localparam int XLEN        = 32;
    localparam int FETCH_WIDTH = 2;
    localparam int FQ_DEPTH    = 16;
    localparam int FQ_PTR_W    = $clog2(FQ_DEPTH);
    localparam int FQ_CNT_W    = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;
endpackage
`default_nettype wire

// File: rtl/popcount_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_lanes
//  Purpose  : Number of set bits in a per-lane valid vector.
//  Revision : 1.0  initial release
// ============================================================================
module popcount_lanes #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]             lanes,
    output logic [$clog2(WIDTH+1)-1:0]   count
);
    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(lanes[i]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Circular instruction buffer between fetch and decode; compacts
//             sparse fetch bundles and presents the oldest lanes to decode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH       = core_pkg::FQ_DEPTH,
    parameter int FETCH_WIDTH = core_pkg::FETCH_WIDTH,
    parameter int XLEN        = core_pkg::XLEN
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [FETCH_WIDTH-1:0]              fetch_valid,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0]    fetch_pc,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0]    fetch_instr,
    output logic                                fq_ready,
    output logic [FETCH_WIDTH-1:0]              fq_valid,
    output logic [FETCH_WIDTH-1:0][XLEN-1:0]    fq_pc,
    output logic [FETCH_WIDTH-1:0][XLEN-1:0]    fq_instr,
    input  logic                                decode_stall,
    output logic [$clog2(DEPTH+1)-1:0]          fq_count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LCNT_W = $clog2(FETCH_WIDTH + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);

    logic [XLEN-1:0]   pc_q    [DEPTH];
    logic [XLEN-1:0]   instr_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              kill;
    logic              accept;
    logic [LCNT_W-1:0] valid_cnt;
    logic [LCNT_W-1:0] out_cnt;
    logic [LCNT_W-1:0] n_enq;
    logic [LCNT_W-1:0] n_deq;
    logic [PTR_W-1:0]  wr_ofs;
    logic [PTR_W-1:0]  wr_idx [FETCH_WIDTH];

    assign kill     = reset | flush;
    // Readiness looks only at the current count; a same-cycle pop is not credited.
    assign fq_ready = !kill && (count <= READY_MAX);
    assign accept   = fq_ready && (|fetch_valid);
    assign fq_count = count;

    popcount_lanes #(.WIDTH(FETCH_WIDTH)) u_pop_enq (
        .lanes (fetch_valid),
        .count (valid_cnt)
    );

    popcount_lanes #(.WIDTH(FETCH_WIDTH)) u_pop_deq (
        .lanes (fq_valid),
        .count (out_cnt)
    );

    assign n_enq = accept       ? valid_cnt : '0;
    assign n_deq = decode_stall ? '0        : out_cnt;

    // Valid lanes land in consecutive slots from tail, skipping invalid lanes.
    always_comb begin
        wr_ofs = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i] = tail + wr_ofs;
            wr_ofs    = wr_ofs + PTR_W'(fetch_valid[i]);
        end
    end

    // Output lanes never look at decode_stall, keeping decode's stall loop-free.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fq_valid[i] = !kill && (count > CNT_W'(i));
            fq_pc[i]    = fq_valid[i] ? pc_q[head + PTR_W'(i)]    : '0;
            fq_instr[i] = fq_valid[i] ? instr_q[head + PTR_W'(i)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (fetch_valid[i]) begin
                    pc_q[wr_idx[i]]    <= fetch_pc[i];
                    instr_q[wr_idx[i]] <= fetch_instr[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Scoreboard bench for fetch_queue against an in-order queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
    localparam int FW    = 2;
    localparam int XL    = 32;
    localparam int DEPTH = 16;

    typedef struct {
        logic [XL-1:0] pc;
        logic [XL-1:0] instr;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [FW-1:0]        fetch_valid;
    logic [FW-1:0][XL-1:0] fetch_pc;
    logic [FW-1:0][XL-1:0] fetch_instr;
    logic                 fq_ready;
    logic [FW-1:0]        fq_valid;
    logic [FW-1:0][XL-1:0] fq_pc;
    logic [FW-1:0][XL-1:0] fq_instr;
    logic                 decode_stall;
    logic [4:0]           fq_count;

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_instr  (fetch_instr),
        .fq_ready     (fq_ready),
        .fq_valid     (fq_valid),
        .fq_pc        (fq_pc),
        .fq_instr     (fq_instr),
        .decode_stall (decode_stall),
        .fq_count     (fq_count)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   last_count = 0;
    bit   mon_en     = 1'b0;

    task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares what the DUT presents against the model queue, then retires.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [FW-1:0] ev;
            int pre;
            pre = sb.size();
            last_count = pre;
            for (int i = 0; i < FW; i++) ev[i] = (i < pre) && !flush && !reset;
            check("fq_valid", XL'(fq_valid), XL'(ev));
            check("fq_count", XL'(fq_count), XL'(pre));
            check("fq_ready", XL'(fq_ready), XL'(!flush && !reset && (pre <= DEPTH - FW)));
            for (int i = 0; i < FW; i++) begin
                check($sformatf("fq_pc[%0d]", i),    fq_pc[i],    ev[i] ? sb[i].pc    : '0);
                check($sformatf("fq_instr[%0d]", i), fq_instr[i], ev[i] ? sb[i].instr : '0);
            end
            if (flush || reset) begin
                sb.delete();
            end else if (!decode_stall) begin
                for (int i = 0; i < FW; i++) if (ev[i]) void'(sb.pop_front());
            end
        end
    end

    // Stimulus: drive one cycle; any bundle the queue takes is pushed as expected output.
    task automatic cycle(input logic [FW-1:0] v, input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                         input logic st, input logic fl, input logic rs, output logic acc);
        ent_t e;
        fetch_valid    = v;
        fetch_pc[0]    = p0;
        fetch_pc[1]    = p1;
        fetch_instr[0] = p0 ^ 32'h5a5a_0013;
        fetch_instr[1] = p1 ^ 32'h5a5a_0013;
        decode_stall   = st;
        flush          = fl;
        reset          = rs;
        @(negedge clk);
        #1;
        acc = !fl && !rs && (last_count <= DEPTH - FW) && (v != '0);
        if (acc) begin
            for (int i = 0; i < FW; i++) begin
                if (v[i]) begin
                    e.pc    = fetch_pc[i];
                    e.instr = fetch_instr[i];
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st, input int n);
        logic a;
        for (int k = 0; k < n; k++) cycle(2'b00, 0, 0, st, 1'b0, 1'b0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic          a;
        logic [FW-1:0] v;
        logic [XL-1:0] p [FW];
        logic [XL-1:0] next_pc;
        int            sent;
        int            guard;

        reset = 1'b1; flush = 1'b0; decode_stall = 1'b0;
        fetch_valid = '0; fetch_pc = '0; fetch_instr = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset for two cycles with a bundle that must not be stored
        cycle(2'b11, 32'h900, 32'h904, 1'b0, 1'b0, 1'b1, a);
        cycle(2'b11, 32'h900, 32'h904, 1'b0, 1'b0, 1'b1, a);
        idle(1'b0, 2);

        // Basic flow
        cycle(2'b11, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, a);
        idle(1'b0, 2);

        // Compaction while stalled
        cycle(2'b10, 32'h0, 32'h204, 1'b1, 1'b0, 1'b0, a);
        cycle(2'b01, 32'h208, 32'h0, 1'b1, 1'b0, 1'b0, a);
        idle(1'b1, 1);
        idle(1'b0, 2);

        // Fill to full, then one bundle that must bounce, then drain
        for (int b = 0; b < 9; b++)
            cycle(2'b11, 32'h1000 + b * 8, 32'h1004 + b * 8, 1'b1, 1'b0, 1'b0, a);
        idle(1'b1, 1);
        idle(1'b0, 10);

        // Sequential stream across pointer wrap with random stalls; fetch holds on refusal
        next_pc = 32'h4000;
        sent = 0;
        guard = 0;
        v = '0;
        while (sent < 40 && guard < 1000) begin
            if (v == '0) begin
                v = FW'($urandom_range(1, 3));
                for (int i = 0; i < FW; i++) begin
                    p[i] = 0;
                    if (v[i] && sent < 40) begin
                        p[i] = next_pc;
                        next_pc += 4;
                        sent++;
                    end else begin
                        v[i] = 1'b0;
                    end
                end
            end
            cycle(v, p[0], p[1], 1'($urandom_range(0, 1)), 1'b0, 1'b0, a);
            if (a) v = '0;
            guard++;
        end
        while (v != '0 && guard < 1000) begin
            cycle(v, p[0], p[1], 1'b0, 1'b0, 1'b0, a);
            if (a) v = '0;
            guard++;
        end
        vectors++;
        if (guard >= 1000) begin
            miscompares++;
            $display("FAIL stream_budget: got %0d cycles, required < 1000", guard);
        end
        idle(1'b0, 12);

        // Flush with count=7 and a bundle in flight
        cycle(2'b11, 32'h800, 32'h804, 1'b1, 1'b0, 1'b0, a);
        cycle(2'b11, 32'h808, 32'h80c, 1'b1, 1'b0, 1'b0, a);
        cycle(2'b11, 32'h810, 32'h814, 1'b1, 1'b0, 1'b0, a);
        cycle(2'b01, 32'h818, 32'h0, 1'b1, 1'b0, 1'b0, a);
        cycle(2'b11, 32'h820, 32'h824, 1'b1, 1'b1, 1'b0, a);
        cycle(2'b11, 32'ha00, 32'ha04, 1'b0, 1'b0, 1'b0, a);
        idle(1'b0, 2);

        // Fully random traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            cycle(FW'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 59) == 0), a);
        end
        idle(1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
